// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_scan_pkg;
    localparam int KEY_ROWS           = 4;
    localparam int KEY_COLS           = 4;
    localparam int DEF_ROW_DWELL      = 50000;  // 1 ms per row at 50 MHz
    localparam int DEF_DEBOUNCE_SCANS = 20;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_e;
endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous pin inputs.
module sync2 #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: walks an active-low row, debounces one latched key,
// and reports press/release as single-cycle pulses.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int ROW_DWELL      = DEF_ROW_DWELL,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_COLS-1:0] col_in,
    output logic [KEY_ROWS-1:0] row_out,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_release,
    output logic                key_down
);
    localparam int DW = $clog2(ROW_DWELL);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
    localparam logic [SW-1:0] STAB_DONE  = SW'(DEBOUNCE_SCANS);

    logic [KEY_COLS-1:0] col_s;

    sync2 #(.W(KEY_COLS), .RST_VAL({KEY_COLS{1'b1}})) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_in),
        .q   (col_s)
    );

    state_e              state_q,       state_d;
    logic [1:0]          row_q,         row_d;
    logic [KEY_ROWS-1:0] row_out_q,     row_out_d;
    logic [DW-1:0]       dwell_q,       dwell_d;
    logic [SW-1:0]       stab_q,        stab_d;
    logic [1:0]          lat_row_q,     lat_row_d;
    logic [1:0]          lat_col_q,     lat_col_d;
    logic [3:0]          key_code_q,    key_code_d;
    logic                key_valid_q,   key_valid_d;
    logic                key_release_q, key_release_d;
    logic                key_down_q,    key_down_d;

    logic          sample;
    logic          accept;
    logic          latched_open;
    logic [1:0]    low_col;
    logic [SW-1:0] stab_inc;

    always_comb begin
        sample       = (dwell_q == DWELL_LAST);
        latched_open = col_s[lat_col_q];
        stab_inc     = stab_q + SW'(1);

        // Column 0 wins when several columns read low.
        low_col = '0;
        for (int i = KEY_COLS - 1; i >= 0; i--) begin
            if (!col_s[i]) low_col = 2'(i);
        end

        state_d       = state_q;
        row_d         = row_q;
        dwell_d       = sample ? '0 : dwell_q + DW'(1);
        stab_d        = stab_q;
        lat_row_d     = lat_row_q;
        lat_col_d     = lat_col_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        key_down_d    = key_down_q & ~key_release_q;
        accept        = 1'b0;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (&col_s) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        lat_row_d = row_q;
                        lat_col_d = low_col;
                        stab_d    = SW'(1);
                        if (DEBOUNCE_SCANS == 1) accept = 1'b1;
                        else                     state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!latched_open) begin
                        if (stab_inc == STAB_DONE) accept = 1'b1;
                        else                       stab_d = stab_inc;
                    end else begin
                        state_d = SCAN;
                        row_d   = row_q + 2'd1;
                        stab_d  = '0;
                    end
                end
                HELD: begin
                    if (!latched_open) begin
                        stab_d = '0;
                    end else if (stab_inc == STAB_DONE) begin
                        key_release_d = 1'b1;
                        state_d       = SCAN;
                        row_d         = row_q + 2'd1;
                        stab_d        = '0;
                    end else begin
                        stab_d = stab_inc;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (accept) begin
            key_code_d  = {lat_row_d, lat_col_d};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = HELD;
            stab_d      = '0;
        end

        row_out_d = ~(KEY_ROWS'(1) << row_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SCAN;
            row_q         <= '0;
            row_out_q     <= 4'b1110;
            dwell_q       <= '0;
            stab_q        <= '0;
            lat_row_q     <= '0;
            lat_col_q     <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_down_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            row_out_q     <= row_out_d;
            dwell_q       <= dwell_d;
            stab_q        <= stab_d;
            lat_row_q     <= lat_row_d;
            lat_col_q     <= lat_col_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
            key_down_q    <= key_down_d;
        end
    end

    assign row_out     = row_out_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;
    assign key_down    = key_down_q;
endmodule
